mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported, variable-latency memory between the IF-stage fetch port (I) and the MEM-stage load/store port (D) of the pipelined CPU.
- Sequences each access through issue, wait and response phases.
- Issues stall indications that feed HazardDetection.
- Gives D priority, with a starvation guard for I, and supports cancelling an in-flight fetch on a pipeline flush.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MAX_DSTREAK, 3: maximum consecutive D grants while I is waiting, before I is forced through.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous reset, active-high.
- i_req_i  in  1  fetch request; level, held until i_ack_o or i_kill_i.
- i_addr_i  in  ADDR_W  fetch address; stable while i_req_i is high.
- i_kill_i  in  1  flush: abandon the pending or in-flight fetch.
- i_ack_o  out  1  one-cycle pulse; i_rdata_o valid.
- i_rdata_o  out  DATA_W  fetched word.
- d_req_i  in  1  data request; level, held until d_ack_o.
- d_we_i  in  1  1 = store, 0 = load.
- d_addr_i  in  ADDR_W  data address.
- d_wdata_i  in  DATA_W  store data.
- d_ack_o  out  1  one-cycle pulse; d_rdata_o valid (loads).
- d_rdata_o  out  DATA_W  load data.
- i_stall_o  out  1  i_req_i & ~i_ack_o.
- d_stall_o  out  1  d_req_i & ~d_ack_o.
- mem_en_o  out  1  one-cycle request strobe to memory.
- mem_we_o  out  1  write enable, held through the transaction.
- mem_addr_o  out  ADDR_W  held from ISSUE until mem_ack_i.
- mem_wdata_o  out  DATA_W  held from ISSUE until mem_ack_i.
- mem_ack_i  in  1  memory done; mem_rdata_i valid in the same cycle.
- mem_rdata_i  in  DATA_W  memory read data.

Behaviour:
- Reset: state = IDLE; all *_o = 0, including data and address registers; streak counter = 0.
  - Reset mid-transaction aborts it immediately; no ack is issued.
- FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE, grant selection:
  - If d_req_i and (streak < MAX_DSTREAK or !i_req_i): grant D.
  - Else if i_req_i and !i_kill_i: grant I.
  - On a grant, latch owner, we, addr and wdata, then go to ISSUE.
- ISSUE (one cycle):
  - mem_en_o = 1; mem_we_o, mem_addr_o and mem_wdata_o come from the latched values.
  - If mem_ack_i is seen in ISSUE, go to RESP; else go to WAIT.
- WAIT:
  - mem_en_o = 0; address, data and we stay stable.
  - On mem_ack_i, register mem_rdata_i into the owner's rdata and go to RESP.
- RESP (one cycle):
  - Pulse the owner's ack; return to IDLE.
  - No grant is made in RESP, so the requester has one cycle to drop or change its request.
- Minimum latency: request seen in IDLE at cycle 0 -> ISSUE at cycle 1 -> ack at cycle 2 with zero-wait memory. In general, ack comes 1 cycle after mem_ack_i.
- Starvation guard:
  - streak increments on each D grant made while i_req_i is high.
  - streak clears on an I grant, or on any IDLE cycle with !i_req_i.
  - streak saturates at MAX_DSTREAK.
- Kill:
  - i_kill_i with the I fetch not yet granted: no grant is made.
  - i_kill_i while I owns ISSUE/WAIT: the transaction completes on memory, and a sticky kill flag suppresses i_ack_o in RESP.
  - i_kill_i in RESP, I owner: i_ack_o is suppressed.
  - The kill flag clears on return to IDLE.
  - A kill has no effect on D transactions.
- i_rdata_o and d_rdata_o hold their last value until overwritten. A store leaves d_rdata_o unchanged.
- Simultaneous i_req_i and d_req_i in IDLE with streak < MAX_DSTREAK: D wins.
- Requests are not queued; a requester is served only while its req is high in IDLE.

Decomposition:
- Shared package:
  - state encoding (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3)
  - owner encoding (OWN_I=1'b0, OWN_D=1'b1)
  - default widths
- One sub-module: mem_arb_priority. It is combinational grant selection plus the registered streak counter, taking i_req, d_req, kill and grant_fire, and returning grant_i and grant_d.

Test Plan:
- Single fetch, zero-wait memory: i_req at addr 0x10, mem_ack_i in ISSUE with rdata 0x8C080000 -> mem_en_o in cycle 1, i_ack_o in cycle 2 with i_rdata_o = 0x8C080000, i_stall_o high in cycles 0-1.
- Store with 3 wait cycles: d_we=1, addr 0x04, wdata 0x5 -> mem_addr_o and mem_wdata_o stable for 4 cycles, d_ack_o 1 cycle after mem_ack_i, d_rdata_o unchanged.
- Contention: i_req and d_req high continuously, 1-cycle memory -> grant order D, D, D, I, D, D, D, I; no I wait exceeds 3 D transactions.
- Kill in WAIT: I granted, i_kill_i pulsed before mem_ack_i -> the memory transaction completes, i_ack_o stays 0, next IDLE serves a pending d_req.
- Reset mid-WAIT: rst_i asserted -> all outputs 0 in the same cycle; after release, a fresh i_req completes normally.
- Back-to-back D: d_req held high after ack with a new address 0x08 -> RESP cycle with no grant, then ISSUE for 0x08.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the I/D memory port arbiter.
// Imported by the interface, the priority sub-module and the top.
package mem_port_arbiter_pkg;

    localparam int ADDR_W_DEF      = 32;
    localparam int DATA_W_DEF      = 32;
    localparam int MAX_DSTREAK_DEF = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    // Width of a counter able to hold 0..max inclusive.
    function automatic int streak_w(input int max);
        return (max < 1) ? 1 : $clog2(max + 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, load/store port, stall outputs and memory port.
// Handshake: i_req_i/d_req_i are levels held until the matching one-cycle ack.
import mem_port_arbiter_pkg::*;

interface mem_port_arbiter_if #(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              i_req_i;
    logic [ADDR_W-1:0] i_addr_i;
    logic              i_kill_i;
    logic              i_ack_o;
    logic [DATA_W-1:0] i_rdata_o;

    logic              d_req_i;
    logic              d_we_i;
    logic [ADDR_W-1:0] d_addr_i;
    logic [DATA_W-1:0] d_wdata_i;
    logic              d_ack_o;
    logic [DATA_W-1:0] d_rdata_o;

    logic              i_stall_o;
    logic              d_stall_o;

    logic              mem_en_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic              mem_ack_i;
    logic [DATA_W-1:0] mem_rdata_i;

    modport slave (
        input  i_req_i, i_addr_i, i_kill_i,
        input  d_req_i, d_we_i, d_addr_i, d_wdata_i,
        input  mem_ack_i, mem_rdata_i,
        output i_ack_o, i_rdata_o, d_ack_o, d_rdata_o,
        output i_stall_o, d_stall_o,
        output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

    modport master (
        output i_req_i, i_addr_i, i_kill_i,
        output d_req_i, d_we_i, d_addr_i, d_wdata_i,
        output mem_ack_i, mem_rdata_i,
        input  i_ack_o, i_rdata_o, d_ack_o, d_rdata_o,
        input  i_stall_o, d_stall_o,
        input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

endinterface

// File: rtl/mem_port_arbiter_priority.sv
// Grant selection for the shared memory port: D first, but after MAX_DSTREAK
// consecutive D grants with I waiting, I is forced through.
module mem_arb_priority
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX_DSTREAK = MAX_DSTREAK_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic i_req_i,
    input  logic d_req_i,
    input  logic kill_i,
    input  logic grant_fire_i,
    output logic grant_i_o,
    output logic grant_d_o
);

    localparam int SW = streak_w(MAX_DSTREAK);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);

    logic [SW-1:0] streak_q, streak_d;
    logic          d_ok;
    logic          gnt_i;
    logic          gnt_d;

    always_comb begin
        d_ok  = d_req_i && ((streak_q < STREAK_MAX) || !i_req_i);
        gnt_d = grant_fire_i && d_ok;
        gnt_i = grant_fire_i && !d_ok && i_req_i && !kill_i;
    end

    // Streak only counts D wins that actually kept a waiting I out.
    always_comb begin
        streak_d = streak_q;
        if (grant_fire_i) begin
            if (gnt_i || !i_req_i) begin
                streak_d = '0;
            end else if (gnt_d && (streak_q != STREAK_MAX)) begin
                streak_d = streak_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

    assign grant_i_o = gnt_i;
    assign grant_d_o = gnt_d;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory between the fetch (I) and load/store (D)
// ports: IDLE -> ISSUE -> WAIT -> RESP, with flush-kill of in-flight fetches.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int MAX_DSTREAK = MAX_DSTREAK_DEF
) (
    input  logic   clk_i,
    input  logic   rst_i,
    mem_port_arbiter_if.slave bus,
    output state_e dbg_state_o
);

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              kill_q, kill_d;

    logic grant_fire;
    logic grant_i;
    logic grant_d;
    logic busy;

    assign grant_fire = (state_q == IDLE);
    assign busy       = (state_q == ISSUE) || (state_q == WAIT);

    mem_arb_priority #(
        .MAX_DSTREAK (MAX_DSTREAK)
    ) u_priority (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .i_req_i      (bus.i_req_i),
        .d_req_i      (bus.d_req_i),
        .kill_i       (bus.i_kill_i),
        .grant_fire_i (grant_fire),
        .grant_i_o    (grant_i),
        .grant_d_o    (grant_d)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_i || grant_d) state_d = ISSUE;
            ISSUE:   state_d = bus.mem_ack_i ? RESP : WAIT;
            WAIT:    if (bus.mem_ack_i) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        owner_d   = owner_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        kill_d    = kill_q;

        if (state_q == IDLE) begin
            kill_d = 1'b0;
            if (grant_d) begin
                owner_d = OWN_D;
                we_d    = bus.d_we_i;
                addr_d  = bus.d_addr_i;
                wdata_d = bus.d_wdata_i;
            end else if (grant_i) begin
                owner_d = OWN_I;
                we_d    = 1'b0;
                addr_d  = bus.i_addr_i;
                wdata_d = '0;
            end
        end else if ((owner_q == OWN_I) && bus.i_kill_i) begin
            kill_d = 1'b1;
        end

        // An abandoned fetch must not clobber the last good instruction word.
        if (busy && bus.mem_ack_i) begin
            if ((owner_q == OWN_D) && !we_q) begin
                d_rdata_d = bus.mem_rdata_i;
            end else if ((owner_q == OWN_I) && !kill_q && !bus.i_kill_i) begin
                i_rdata_d = bus.mem_rdata_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            owner_q   <= OWN_I;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            kill_q    <= 1'b0;
        end else begin
            owner_q   <= owner_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            kill_q    <= kill_d;
        end
    end

    // Stalls are gated by reset so every output reads zero while it is held.
    always_comb begin
        bus.mem_en_o    = (state_q == ISSUE);
        bus.mem_we_o    = we_q;
        bus.mem_addr_o  = addr_q;
        bus.mem_wdata_o = wdata_q;
        bus.i_ack_o     = (state_q == RESP) && (owner_q == OWN_I) && !kill_q && !bus.i_kill_i;
        bus.d_ack_o     = (state_q == RESP) && (owner_q == OWN_D);
        bus.i_rdata_o   = i_rdata_q;
        bus.d_rdata_o   = d_rdata_q;
        bus.i_stall_o   = !rst_i && bus.i_req_i && !bus.i_ack_o;
        bus.d_stall_o   = !rst_i && bus.d_req_i && !bus.d_ack_o;
        dbg_state_o     = state_q;
    end

    a_one_ack: assert property (@(posedge clk_i) disable iff (rst_i)
        !(bus.i_ack_o && bus.d_ack_o));

    a_addr_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (state_q == WAIT) |-> ($stable(addr_q) && $stable(wdata_q) && $stable(we_q)));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: memory model, driver tasks, and a
// scoreboard whose monitor pops {port, data} on every ack.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int W  = DW + 1;

    logic   clk_i;
    logic   rst_i;
    state_e dbg_state;

    int vectors;
    int miscompares;
    int mem_lat;
    logic [W-1:0] exp_q[$];

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_arbiter #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .MAX_DSTREAK (3)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock ----------------
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // ---------------- memory model ----------------
    logic [31:0] mem_a [logic [31:0]];

    function automatic logic [31:0] rd(input logic [31:0] a);
        return mem_a.exists(a) ? mem_a[a] : 32'hDEAD_BEEF;
    endfunction

    initial begin
        logic [31:0] cur;
        int          cnt;
        bit          pend;
        mem_a[32'h04] = 32'h1111_0004;
        mem_a[32'h08] = 32'h2222_0008;
        mem_a[32'h0C] = 32'h3333_000C;
        mem_a[32'h10] = 32'h8C08_0000;
        mem_a[32'h14] = 32'h2042_0001;
        mem_a[32'h18] = 32'h0BAD_F00D;
        mem_a[32'h20] = 32'h7777_0020;
        mem_a[32'h40] = 32'h4444_0040;
        mem_a[32'h44] = 32'h5555_0044;
        mem_a[32'h48] = 32'h6666_0048;
        bus.mem_ack_i   = 1'b0;
        bus.mem_rdata_i = '0;
        pend = 1'b0;
        cnt  = 0;
        cur  = '0;
        forever begin
            @(negedge clk_i);
            bus.mem_ack_i = 1'b0;
            if (rst_i) begin
                pend = 1'b0;
            end else if (bus.mem_en_o) begin
                cur = bus.mem_addr_o;
                if (bus.mem_we_o) mem_a[cur] = bus.mem_wdata_o;
                if (mem_lat == 0) begin
                    bus.mem_ack_i   = 1'b1;
                    bus.mem_rdata_i = rd(cur);
                end else begin
                    cnt  = mem_lat;
                    pend = 1'b1;
                end
            end else if (pend) begin
                cnt = cnt - 1;
                if (cnt == 0) begin
                    pend            = 1'b0;
                    bus.mem_ack_i   = 1'b1;
                    bus.mem_rdata_i = rd(cur);
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors = vectors + 1;
        if (act !== exp) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_ack(input bit is_d, input string nm);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 64 && !seen; k++) begin
            @(negedge clk_i);
            seen = is_d ? bus.d_ack_o : bus.i_ack_o;
        end
        check({nm, "_ack_seen"}, 64'(seen), 64'(1));
    endtask

    task automatic wait_state(input state_e s, input string nm);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 64 && !seen; k++) begin
            @(negedge clk_i);
            seen = (dbg_state == s);
        end
        check({nm, "_state_reached"}, 64'(seen), 64'(1));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_i_ack"},     64'(bus.i_ack_o),     64'(0));
        check({tag, "_d_ack"},     64'(bus.d_ack_o),     64'(0));
        check({tag, "_i_stall"},   64'(bus.i_stall_o),   64'(0));
        check({tag, "_d_stall"},   64'(bus.d_stall_o),   64'(0));
        check({tag, "_mem_en"},    64'(bus.mem_en_o),    64'(0));
        check({tag, "_mem_we"},    64'(bus.mem_we_o),    64'(0));
        check({tag, "_mem_addr"},  64'(bus.mem_addr_o),  64'(0));
        check({tag, "_mem_wdata"}, 64'(bus.mem_wdata_o), 64'(0));
        check({tag, "_i_rdata"},   64'(bus.i_rdata_o),   64'(0));
        check({tag, "_d_rdata"},   64'(bus.d_rdata_o),   64'(0));
        check({tag, "_state"},     64'(dbg_state),       64'(IDLE));
    endtask

    function automatic logic [W-1:0] exp_i(input logic [31:0] d);
        return {1'b0, d};
    endfunction

    function automatic logic [W-1:0] exp_d(input logic [31:0] d);
        return {1'b1, d};
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        vectors     = 0;
        miscompares = 0;
        mem_lat     = 0;
        rst_i          = 1'b1;
        bus.i_req_i    = 1'b0;
        bus.i_addr_i   = '0;
        bus.i_kill_i   = 1'b0;
        bus.d_req_i    = 1'b0;
        bus.d_we_i     = 1'b0;
        bus.d_addr_i   = '0;
        bus.d_wdata_i  = '0;

        fork
            begin : monitor
                logic [W-1:0] got;
                logic [W-1:0] exp;
                forever begin
                    @(negedge clk_i);
                    if (!rst_i && (bus.i_ack_o || bus.d_ack_o)) begin
                        got = {bus.d_ack_o, bus.d_ack_o ? bus.d_rdata_o : bus.i_rdata_o};
                        check("dual_ack", 64'(bus.i_ack_o & bus.d_ack_o), 64'(0));
                        if (exp_q.size() == 0) begin
                            vectors     = vectors + 1;
                            miscompares = miscompares + 1;
                            $display("FAIL unexpected_ack: got 0x%0h, expected no ack (t=%0t)", got, $time);
                        end else begin
                            exp = exp_q.pop_front();
                            check("ack_resp", 64'(got), 64'(exp));
                        end
                    end
                end
            end
            begin : watchdog
                #200000;
                $display("FAIL watchdog: got timeout, expected completion");
                $fatal(1, "bench timeout");
            end
        join_none

        // Reset state
        @(negedge clk_i);
        check_all_zero("reset");
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        tick();

        // 1. Single fetch, zero-wait memory
        mem_lat      = 0;
        bus.i_addr_i = 32'h10;
        bus.i_req_i  = 1'b1;
        exp_q.push_back(exp_i(32'h8C08_0000));
        @(negedge clk_i);
        check("t1_c0_state",   64'(dbg_state),     64'(IDLE));
        check("t1_c0_i_stall", 64'(bus.i_stall_o), 64'(1));
        @(negedge clk_i);
        check("t1_c1_mem_en",  64'(bus.mem_en_o),   64'(1));
        check("t1_c1_addr",    64'(bus.mem_addr_o), 64'(32'h10));
        check("t1_c1_we",      64'(bus.mem_we_o),   64'(0));
        check("t1_c1_i_stall", 64'(bus.i_stall_o),  64'(1));
        wait_ack(1'b0, "t1");
        check("t1_c2_state",   64'(dbg_state),     64'(RESP));
        check("t1_c2_i_stall", 64'(bus.i_stall_o), 64'(0));
        tick();
        bus.i_req_i = 1'b0;

        // 2. Back-to-back D loads, address changes after the ack
        bus.d_we_i   = 1'b0;
        bus.d_addr_i = 32'h04;
        bus.d_req_i  = 1'b1;
        exp_q.push_back(exp_d(32'h1111_0004));
        exp_q.push_back(exp_d(32'h2222_0008));
        wait_ack(1'b1, "t2a");
        check("t2_resp_no_en", 64'(bus.mem_en_o), 64'(0));
        tick();
        bus.d_addr_i = 32'h08;
        @(negedge clk_i);
        check("t2_idle_after_resp", 64'(dbg_state), 64'(IDLE));
        @(negedge clk_i);
        check("t2_issue",      64'(dbg_state),      64'(ISSUE));
        check("t2_issue_addr", 64'(bus.mem_addr_o), 64'(32'h08));
        wait_ack(1'b1, "t2b");
        tick();
        bus.d_req_i = 1'b0;

        // 3. Store with 3 wait cycles; d_rdata must keep the last load value
        mem_lat       = 3;
        bus.d_we_i    = 1'b1;
        bus.d_addr_i  = 32'h04;
        bus.d_wdata_i = 32'h5;
        bus.d_req_i   = 1'b1;
        exp_q.push_back(exp_d(32'h2222_0008));
        @(negedge clk_i);
        check("t3_d_stall", 64'(bus.d_stall_o), 64'(1));
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            check("t3_addr_hold",  64'(bus.mem_addr_o),  64'(32'h04));
            check("t3_wdata_hold", 64'(bus.mem_wdata_o), 64'(32'h5));
            check("t3_we_hold",    64'(bus.mem_we_o),    64'(1));
            check("t3_en_pulse",   64'(bus.mem_en_o),    64'(k == 0));
        end
        @(negedge clk_i);
        check("t3_d_ack", 64'(bus.d_ack_o), 64'(1));
        tick();
        bus.d_req_i = 1'b0;
        bus.d_we_i  = 1'b0;

        // 4. Contention: order D, D, D, I, D, D, D, I
        mem_lat = 0;
        exp_q.push_back(exp_d(32'h0000_0005));
        exp_q.push_back(exp_d(32'h2222_0008));
        exp_q.push_back(exp_d(32'h3333_000C));
        exp_q.push_back(exp_i(32'h8C08_0000));
        exp_q.push_back(exp_d(32'h4444_0040));
        exp_q.push_back(exp_d(32'h5555_0044));
        exp_q.push_back(exp_d(32'h6666_0048));
        exp_q.push_back(exp_i(32'h2042_0001));
        bus.i_addr_i = 32'h10;
        bus.i_req_i  = 1'b1;
        bus.d_addr_i = 32'h04;
        bus.d_req_i  = 1'b1;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    bus.d_addr_i = (i < 3) ? 32'(4 * (i + 1)) : 32'(32'h40 + 4 * (i - 3));
                    wait_ack(1'b1, "t4_d");
                    tick();
                end
                bus.d_req_i = 1'b0;
            end
            begin
                wait_ack(1'b0, "t4_i0");
                tick();
                bus.i_addr_i = 32'h14;
                wait_ack(1'b0, "t4_i1");
                tick();
                bus.i_req_i = 1'b0;
            end
        join
        tick();

        // 5. Kill in WAIT: memory finishes, no i_ack, pending D served next
        mem_lat      = 3;
        bus.i_addr_i = 32'h18;
        bus.i_req_i  = 1'b1;
        wait_state(WAIT, "t5_wait");
        tick();
        bus.i_kill_i = 1'b1;
        bus.i_req_i  = 1'b0;
        bus.d_we_i   = 1'b0;
        bus.d_addr_i = 32'h20;
        bus.d_req_i  = 1'b1;
        exp_q.push_back(exp_d(32'h7777_0020));
        tick();
        bus.i_kill_i = 1'b0;
        wait_state(RESP, "t5_resp");
        check("t5_no_i_ack", 64'(bus.i_ack_o), 64'(0));
        wait_ack(1'b1, "t5_d");
        tick();
        bus.d_req_i = 1'b0;

        // 6. Kill before grant: no grant is made
        bus.i_addr_i = 32'h10;
        bus.i_req_i  = 1'b1;
        bus.i_kill_i = 1'b1;
        @(negedge clk_i);
        check("t6_idle0", 64'(dbg_state), 64'(IDLE));
        tick();
        @(negedge clk_i);
        check("t6_idle1",  64'(dbg_state),    64'(IDLE));
        check("t6_no_en",  64'(bus.mem_en_o), 64'(0));
        tick();
        bus.i_req_i  = 1'b0;
        bus.i_kill_i = 1'b0;

        // 7. Reset mid-WAIT, then a fresh fetch
        mem_lat      = 3;
        bus.i_addr_i = 32'h18;
        bus.i_req_i  = 1'b1;
        exp_q.push_back(exp_i(32'h0BAD_F00D));
        wait_state(WAIT, "t7_wait");
        tick();
        rst_i       = 1'b1;
        bus.i_req_i = 1'b0;
        #1;
        check_all_zero("t7_rst");
        exp_q.delete();
        tick();
        tick();
        rst_i = 1'b0;
        tick();
        mem_lat      = 1;
        bus.i_addr_i = 32'h10;
        bus.i_req_i  = 1'b1;
        exp_q.push_back(exp_i(32'h8C08_0000));
        wait_ack(1'b0, "t7_fresh");
        tick();
        bus.i_req_i = 1'b0;

        repeat (3) tick();
        check("exp_q_drained", 64'(exp_q.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
